// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI master and its clock generator.
package spi_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } state_t;

endpackage

// File: rtl/spi_clkgen.sv
// Half-period tick generator: tick is high on the last clk cycle of every
// CLK_DIV-cycle interval. reload restarts the interval so each FSM state
// begins with a full half-period.
module spi_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload,
    output logic tick
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div_cnt;

    assign tick = (div_cnt == DIV_LAST);

    // Divider counter: restarts on reload or at the end of each half-period, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= 8'd0;
        end else if (reload || tick) begin
            div_cnt <= 8'd0;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master issuing one 16-bit frame per request:
// {addr[6:0], rw, data[7:0]}, MSB first. Reads return the last 8 bits
// sampled from miso. Outputs decode directly from state so an asynchronous
// reset shows on the pins in the same cycle.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    state_t                  state;
    state_t                  state_nxt;
    logic                    tick;
    logic                    reload;
    logic                    half_low;
    logic [4:0]              bit_cnt;
    logic                    last_bit;
    logic [FRAME_BITS-1:0]   frame;
    logic [DATA_W-1:0]       rx;
    logic                    rw_q;

    spi_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk    (clk),
        .rst_n  (rst_n),
        .reload (reload),
        .tick   (tick)
    );

    assign last_bit = (bit_cnt == 5'(FRAME_BITS - 1));
    // Every state entry restarts both the divider and the bit counter.
    assign reload   = (state_nxt != state);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a request is only looked at while IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETUP;
            SETUP:   if (tick) state_nxt = SHIFT;
            SHIFT:   if (tick && half_low && last_bit) state_nxt = HOLD;
            HOLD:    if (tick) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame shifter, miso capture, SCLK phase and bit counting.
    // The frame shifts at the end of each high phase so mosi moves exactly
    // when sclk falls; miso is taken on that same last high cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame    <= '0;
            rx       <= '0;
            rw_q     <= 1'b0;
            rdata    <= '0;
            half_low <= 1'b0;
            bit_cnt  <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rw_q  <= rw;
                        frame <= {addr, rw, (rw ? {DATA_W{1'b0}} : wdata)};
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!half_low) begin
                            half_low <= 1'b1;
                            frame    <= {frame[FRAME_BITS-2:0], 1'b0};
                            rx       <= {rx[DATA_W-2:0], miso};
                        end else begin
                            half_low <= 1'b0;
                            bit_cnt  <= bit_cnt + 5'd1;
                        end
                    end
                end
                HOLD: begin
                    // Loaded on the way into DONE so rdata is valid alongside done.
                    if (tick && rw_q) rdata <= rx;
                end
                default: ;
            endcase
            if (reload) begin
                half_low <= 1'b0;
                bit_cnt  <= 5'd0;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign cs_n = (state == IDLE) || (state == DONE);
    assign sclk = (state == SHIFT) && !half_low;
    assign mosi = (state == SETUP || state == SHIFT || state == HOLD) ? frame[FRAME_BITS-1] : 1'b0;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLK_DIV 4 and 2) each attached to an
// SPI memory slave. A cycle-level reference derived from the frame timing
// rules checks busy/done/cs_n/sclk/mosi/rdata on every cycle and the
// captured frame at every done; directed cases pin literal values.
module tb_spi_master;

    localparam int N = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start [N];
    logic       rw    [N];
    logic [6:0] addr  [N];
    logic [7:0] wdata [N];
    logic       busy  [N];
    logic       done  [N];
    logic [7:0] rdata [N];
    logic       sclk  [N];
    logic       cs_n  [N];
    logic       mosi  [N];
    logic       miso  [N];

    spi_master #(.CLK_DIV(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .rw(rw[0]), .addr(addr[0]),
        .wdata(wdata[0]), .busy(busy[0]), .done(done[0]), .rdata(rdata[0]),
        .sclk(sclk[0]), .cs_n(cs_n[0]), .mosi(mosi[0]), .miso(miso[0])
    );

    spi_master #(.CLK_DIV(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .rw(rw[1]), .addr(addr[1]),
        .wdata(wdata[1]), .busy(busy[1]), .done(done[1]), .rdata(rdata[1]),
        .sclk(sclk[1]), .cs_n(cs_n[1]), .mosi(mosi[1]), .miso(miso[1])
    );

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] cyc=%0d got=%0h expected=%0h", nm, i, cyc, act, exp);
        end
    endtask

    // Reference model state
    int         acc       [N];
    int         idle_from [N];
    bit         active    [N];
    logic       exp_rw    [N];
    logic [6:0] exp_addr  [N];
    logic [7:0] exp_wdata [N];
    logic [15:0] exp_frame [N];
    logic [7:0] exp_rdata [N];
    logic [7:0] ref_mem   [N][128];

    // Slave (environment) state
    logic [7:0]  smem       [N][128];
    logic [15:0] sh         [N];
    int          bidx       [N];
    int          rises      [N];
    logic [7:0]  tx         [N];
    logic [15:0] last_frame [N];
    int          last_rises [N];
    logic        prev_cs    [N];
    logic        prev_sclk  [N];

    // Request acceptance and reset, seen from the pins at each rising edge
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                active[i]    = 1'b0;
                idle_from[i] = 0;
                exp_rdata[i] = 8'h00;
            end else if (start[i] && cyc >= idle_from[i]) begin
                acc[i]       = cyc;
                active[i]    = 1'b1;
                idle_from[i] = cyc + 34 * div_of(i) + 2;
                exp_rw[i]    = rw[i];
                exp_addr[i]  = addr[i];
                exp_wdata[i] = wdata[i];
                exp_frame[i] = {addr[i], rw[i], (rw[i] ? 8'h00 : wdata[i])};
            end
        end
        cyc++;
    end

    // Slave memory model followed by the per-cycle compare
    always @(negedge clk) begin
        int d, rel, s;
        bit e_busy, e_done, e_cs, e_sclk;
        for (int i = 0; i < N; i++) begin
            if (!cs_n[i]) begin
                if (sclk[i] && !prev_sclk[i]) begin
                    sh[i] = {sh[i][14:0], mosi[i]};
                    bidx[i]++;
                    rises[i]++;
                    if (bidx[i] == 8) tx[i] = sh[i][0] ? smem[i][sh[i][7:1]] : 8'($urandom);
                end else if (!sclk[i] && prev_sclk[i]) begin
                    if (bidx[i] >= 8 && bidx[i] < 16) miso[i] = tx[i][15 - bidx[i]];
                    else miso[i] = 1'($urandom);
                end
            end else begin
                if (!prev_cs[i] && bidx[i] == 16) begin
                    last_frame[i] = sh[i];
                    last_rises[i] = rises[i];
                    if (!sh[i][8]) smem[i][sh[i][15:9]] = sh[i][7:0];
                end
                bidx[i]  = 0;
                rises[i] = 0;
            end
            prev_cs[i]   = cs_n[i];
            prev_sclk[i] = sclk[i];

            d      = div_of(i);
            rel    = cyc - acc[i];
            s      = rel - 1 - d;
            e_busy = active[i] && rel >= 1 && rel <= 34 * d + 1;
            e_done = active[i] && rel == 34 * d + 1;
            e_cs   = !(active[i] && rel >= 1 && rel <= 34 * d);
            e_sclk = active[i] && s >= 0 && s < 32 * d && (s % (2 * d)) < d;
            if (e_done) begin
                if (exp_rw[i]) exp_rdata[i] = ref_mem[i][exp_addr[i]];
                else ref_mem[i][exp_addr[i]] = exp_wdata[i];
            end
            check("busy", i, 32'(busy[i]), 32'(e_busy));
            check("done", i, 32'(done[i]), 32'(e_done));
            check("cs_n", i, 32'(cs_n[i]), 32'(e_cs));
            check("sclk", i, 32'(sclk[i]), 32'(e_sclk));
            check("rdata", i, 32'(rdata[i]), 32'(exp_rdata[i]));
            if (!active[i]) check("mosi_idle", i, 32'(mosi[i]), 32'd0);
            if (e_done) begin
                check("frame", i, 32'(last_frame[i]), 32'(exp_frame[i]));
                check("rises", i, 32'(last_rises[i]), 32'd16);
                last_rises[i] = 0;
                active[i]     = 1'b0;
            end
        end
    end

    // Issue one request, scramble inputs after acceptance, wait for done.
    task automatic run_txn(input int i, input logic r, input logic [6:0] a, input logic [7:0] dat,
                           output int delta);
        bit seen;
        @(negedge clk); #1;
        start[i] = 1'b1; rw[i] = r; addr[i] = a; wdata[i] = dat;
        @(negedge clk); #1;
        start[i] = 1'b0; rw[i] = 1'($urandom); addr[i] = 7'($urandom); wdata[i] = 8'($urandom);
        seen = 0;
        for (int t = 0; t < 40 * div_of(i) + 20; t++) begin
            @(negedge clk); #1;
            if (done[i]) begin seen = 1; break; end
        end
        delta = cyc - acc[i];
        if (!seen) check("done_timeout", i, 32'd0, 32'd1);
    endtask

    initial begin
        int dl, t0;
        bit seen;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            start[i] = 0; rw[i] = 0; addr[i] = 0; wdata[i] = 0; miso[i] = 0;
            active[i] = 0; idle_from[i] = 0; acc[i] = 0; exp_rdata[i] = 0;
            bidx[i] = 0; rises[i] = 0; last_rises[i] = 0; last_frame[i] = 0; sh[i] = 0; tx[i] = 0;
            prev_cs[i] = 1; prev_sclk[i] = 0;
            for (int a = 0; a < 128; a++) begin
                smem[i][a]    = 8'($urandom);
                ref_mem[i][a] = smem[i][a];
            end
        end
        smem[0][127] = 8'h3C; ref_mem[0][127] = 8'h3C;

        #3;
        check("rst_busy", 0, 32'(busy[0]), 0);
        check("rst_done", 0, 32'(done[0]), 0);
        check("rst_cs_n", 0, 32'(cs_n[0]), 1);
        check("rst_sclk", 0, 32'(sclk[0]), 0);
        check("rst_mosi", 0, 32'(mosi[0]), 0);
        check("rst_rdata", 0, 32'(rdata[0]), 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Write 0x15 <- 0xA5
        run_txn(0, 1'b0, 7'h15, 8'hA5, dl);
        check("w_frame_lit", 0, 32'(last_frame[0]), 32'h2AA5);
        check("w_latency", 0, 32'(dl), 32'd137);
        check("w_rdata_keep", 0, 32'(rdata[0]), 32'h00);

        // Read 0x7F, slave returns 0x3C
        run_txn(0, 1'b1, 7'h7F, 8'h99, dl);
        check("r_frame_lit", 0, 32'(last_frame[0]), 32'hFF00);
        check("r_rdata_lit", 0, 32'(rdata[0]), 32'h3C);

        // Start pulses during SHIFT and during DONE are ignored
        @(negedge clk); #1;
        start[0] = 1; rw[0] = 0; addr[0] = 7'h22; wdata[0] = 8'h3E;
        @(negedge clk); #1;
        start[0] = 0;
        repeat (40) @(negedge clk);
        #1 start[0] = 1; addr[0] = 7'h55; wdata[0] = 8'h11;
        @(negedge clk); #1 start[0] = 0;
        seen = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk); #1;
            if (done[0]) begin seen = 1; break; end
        end
        if (!seen) check("ign_timeout", 0, 0, 1);
        check("ign_frame_lit", 0, 32'(last_frame[0]), 32'h443E);
        start[0] = 1; addr[0] = 7'h66; wdata[0] = 8'h77;
        @(negedge clk); #1 start[0] = 0;
        repeat (3) @(negedge clk);
        #1 check("ign_done_cs", 0, 32'(cs_n[0]), 1);

        // Held start: next frame's cs_n falls two cycles after done
        @(negedge clk); #1;
        start[0] = 1; rw[0] = 0; addr[0] = 7'h0C; wdata[0] = 8'hC3;
        seen = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk); #1;
            if (done[0]) begin seen = 1; break; end
        end
        if (!seen) check("held_timeout", 0, 0, 1);
        t0 = cyc;
        seen = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk); #1;
            if (!cs_n[0]) begin seen = 1; break; end
        end
        check("held_cs_gap", 0, 32'(cyc - t0), 32'd2);
        start[0] = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk); #1;
            if (done[0]) break;
        end
        check("held_frame_lit", 0, 32'(last_frame[0]), 32'h18C3);

        // Reset at the 9th SCLK rise aborts the frame
        @(negedge clk); #1;
        start[0] = 1; rw[0] = 0; addr[0] = 7'h40; wdata[0] = 8'h81;
        @(negedge clk); #1 start[0] = 0;
        seen = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk); #1;
            if (rises[0] == 9) begin seen = 1; break; end
        end
        if (!seen) check("rise9_timeout", 0, 0, 1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_cs_n", 0, 32'(cs_n[0]), 1);
        check("abort_sclk", 0, 32'(sclk[0]), 0);
        check("abort_busy", 0, 32'(busy[0]), 0);
        check("abort_done", 0, 32'(done[0]), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        run_txn(0, 1'b0, 7'h01, 8'hFF, dl);
        check("post_rst_frame_lit", 0, 32'(last_frame[0]), 32'h02FF);
        check("post_rst_latency", 0, 32'(dl), 32'd137);

        // CLK_DIV=2: write then read back through the slave memory
        run_txn(1, 1'b0, 7'h10, 8'h5A, dl);
        check("d2_latency", 1, 32'(dl), 32'd69);
        run_txn(1, 1'b1, 7'h10, 8'h00, dl);
        check("d2_rdata_lit", 1, 32'(rdata[1]), 32'h5A);

        // Randomized traffic on both instances over a small address window
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 12; k++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                run_txn(i, 1'($urandom), 7'(8'h30 + $urandom_range(0, 3)), 8'($urandom), dl);
            end
        end

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
